// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the shared shift-add multiplier.
// Holds the FSM encoding, default sizes and the round-robin step.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 4;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_seq_mul_core.sv
// Sequential shift-add multiplier, one add/shift step per cycle.
// prod is the post-step {ac,q}, valid in the cycle done is high.
module seq_mul_core
    import mul_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               run,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   ac;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;

    // {carry,ac} = ac + (q[0] ? m : 0), then {carry,ac,q} >> 1
    always_comb begin
        sum     = {1'b0, ac} + {1'b0, (q[0] ? m : '0)};
        shifted = {sum, q[WIDTH-1:1]};
    end

    assign done = run && (count == CW'(WIDTH - 1));
    assign prod = shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ac    <= '0;
            q     <= '0;
            m     <= '0;
            count <= '0;
        end else if (start) begin
            ac    <= '0;
            q     <= b;
            m     <= a;
            count <= '0;
        end else if (run) begin
            ac    <= shifted[2*WIDTH-1:WIDTH];
            q     <= shifted[WIDTH-1:0];
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end sharing one sequential multiplier.
// Grants in IDLE, steps in RUN, holds the response in DONE.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_prod,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   busy
);

    state_t             state;
    state_t             state_nx;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic               start;
    logic               done;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] prod;

    // first valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign start = rst && (state == IDLE) && found;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        if (start) req_ready[win] = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == ID_W'(k)) begin
                a_sel = req_a[k*WIDTH +: WIDTH];
                b_sel = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (done) state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            rsp_prod <= '0;
            rsp_id   <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                ptr   <= ID_W'(rr_next(int'(win), N_REQ));
                owner <= win;
            end
            if (done) begin
                rsp_prod <= prod;
                rsp_id   <= owner;
            end
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

    seq_mul_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .run  (state == RUN),
        .a    (a_sel),
        .b    (b_sel),
        .done (done),
        .prod (prod)
    );

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 4-bit shift-add sequential multiplier engine among N_REQ requesters.
- Each requester has a valid/ready request channel. There is one common response channel that carries the product and the requester ID.
- A round-robin arbiter grants the engine, a small FSM sequences it, and the result is held until the consumer accepts it.
- The block sits between multiple producer blocks and the multiplier datapath, so several clients can use one engine without contention logic of their own.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WIDTH, 4, operand width; product width is 2*WIDTH.
- ID_W, $clog2(N_REQ), width of rsp_id.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  multipliers, same packing.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_prod  out  2*WIDTH  unsigned product a*b.
- rsp_id  out  ID_W  index of the requester that owns rsp_prod.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; req_ready=0, rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0.
  - Round-robin pointer reset to 0 (requester 0 has highest priority). Engine registers ac/q/m/carry/count are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is combinational and one-hot to the winner: the first requester with req_valid=1, searching from ptr upward and wrapping from N_REQ-1 to 0.
  - All req_ready are 0 if no req_valid is set.
  - Handshake occurs when req_valid[i] and req_ready[i] are both 1.
  - On a handshake: latch m=a_i, q=b_i, ac=0, carry=0, count=0, owner=i; set ptr=(i+1) mod N_REQ; go to RUN.
  - ptr changes only on a grant.
- RUN:
  - req_ready=0. Each cycle does one step: if q[0], then {c,ac}=ac+m, else {c,ac}={0,ac}; then {c,ac,q} is shifted right one bit, with 0 shifted into c.
  - count increments every cycle. After WIDTH steps (count==WIDTH-1 at the edge), go to DONE with rsp_prod={ac,q} and rsp_id=owner registered.
- DONE:
  - rsp_valid=1. rsp_prod and rsp_id stay stable until rsp_valid and rsp_ready are both 1.
  - On that handshake go to IDLE; rsp_valid drops on the next cycle.
  - req_ready=0 throughout DONE; no new request is accepted in this state.
- Latency and throughput:
  - Accept in cycle t → RUN in cycles t+1..t+WIDTH → rsp_valid in cycle t+WIDTH+1.
  - With rsp_ready held at 1, an operation takes WIDTH+2 cycles, and the next grant can occur one cycle after the response handshake.
- Arithmetic: unsigned only. The product is exact, with no overflow (max (2^WIDTH-1)^2, e.g. 225 for WIDTH=4).
- Boundary conditions:
  - A requester may drop req_valid before it is granted; this has no effect and is not an error. Once granted, its operands are captured and later changes on req_a/req_b are ignored.
  - If all requesters are valid, grants rotate strictly, e.g. 0,1,2,3,0…; no requester waits more than N_REQ-1 grants.
  - rsp_ready=1 while rsp_valid=0 is ignored.
  - Reset mid-RUN or mid-DONE aborts the operation; the in-flight result is lost and rsp_valid goes to 0 immediately.
  - Operand 0 on either side gives rsp_prod=0 after the full WIDTH+1 latency; there is no early termination.

Decomposition:
- Package mul_share_pkg: FSM state enum (IDLE/RUN/DONE), default WIDTH/N_REQ constants, and a helper function for round-robin next-index selection.
- Sub-module seq_mul_core: start, a, b → done pulse, prod. It holds ac/q/m/c/count and performs one add-shift step per cycle.
- The top level contains the arbiter, pointer, FSM and response holding registers.

Test Plan:
- Single request: requester 2 sends a=7, b=6 in cycle t → req_ready[2]=1 in cycle t; rsp_valid in cycle t+5 with rsp_prod=42, rsp_id=2.
- All four valid from reset, operands (a=i+1, b=3), rsp_ready=1 → responses arrive with IDs 0,1,2,3,0 and products 3,6,9,12, one every 6 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_prod and rsp_id stay stable, req_ready stays 0 for all requesters, busy=1; raise rsp_ready → IDLE the next cycle.
- Extremes: a=15,b=15 → 225; a=0,b=9 → 0; a=9,b=0 → 0; a=1,b=15 → 15; latency is WIDTH+1 in every case.
- Reset mid-RUN: assert rst=0 two cycles after a grant → rsp_valid=0 and busy=0 asynchronously; after release, requester 0 wins first even if ptr was elsewhere.
- Operand change after grant: change req_a/req_b during RUN → product reflects the captured operands only; a requester that drops req_valid before grant is never granted.
